// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer driving a single external 1-bit ALU slice.
// Operands are latched on start and walked LSB-first, one bit per clock, with the
// slice carry-out fed back as the next bit's carry-in.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_control,
    input  logic             slice_out,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carryout_q, carryout_d;
    logic               overflow_q, overflow_d;

    // Slice drive: current bit of the latched operands plus the carry register.
    assign slice_a       = a_q[idx_q];
    assign slice_b       = b_q[idx_q];
    assign slice_cin     = carry_q;
    assign slice_control = ctrl_q;

    // Status decoded straight from registered state.
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = (result_q == '0);
    assign negative = result_q[WIDTH-1];

    // Next-state and datapath update for the serial walk.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        ctrl_d     = ctrl_q;
        carry_d    = carry_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    ctrl_d   = control;
                    idx_d    = '0;
                    carry_d  = control[0];
                    result_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[idx_q] = slice_out;
                carry_d         = slice_cout;
                if (idx_q == IDX_LAST) begin
                    carryout_d = slice_cout;
                    overflow_d = (slice_cin ^ slice_cout) & ~ctrl_q[2];
                    idx_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctrl_q     <= ctrl_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit ALU slice attached.
module tb_alu_serial_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic [2:0]       control;
    logic             slice_a, slice_b, slice_cin;
    logic [2:0]       slice_control;
    logic             slice_out, slice_cout;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic             carryout, overflow, zero, negative;

    int n_checks = 0;
    int n_fail   = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .control(control),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_control(slice_control), .slice_out(slice_out), .slice_cout(slice_cout),
        .busy(busy), .done(done), .result(result), .carryout(carryout),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    // Slice model: full adder with b-invert on control[0], logic unit, output mux.
    logic b_eff;
    always_comb begin
        b_eff      = slice_b ^ slice_control[0];
        slice_cout = (slice_a & b_eff) | (slice_a & slice_cin) | (b_eff & slice_cin);
        if (!slice_control[2]) begin
            slice_out = slice_a ^ b_eff ^ slice_cin;
        end else begin
            case (slice_control[1:0])
                2'b00:   slice_out = slice_a & slice_b;
                2'b01:   slice_out = slice_a | slice_b;
                2'b10:   slice_out = ~(slice_a | slice_b);
                default: slice_out = slice_a ^ slice_b;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation; hold_start keeps start high and perturbs operands during RUN.
    task automatic run_op(input string tag, input logic [2:0] c, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res, input logic exp_c,
                          input logic exp_v, input logic chk_c, input logic hold_start);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        A = a; B = b; control = c; start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        check({tag, "_cin0"}, 32'(slice_cin), 32'(c[0]));
        if (hold_start) begin
            A = ~a; B = 8'h5A; control = 3'b111;
        end else begin
            start = 1'b0; A = 8'h33; B = 8'hCC;
        end
        cyc = 0;
        busy_cnt = 1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_zero"}, 32'(zero), 32'(exp_res == 8'h00));
        check({tag, "_negative"}, 32'(negative), 32'(exp_res[7]));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_v));
        if (chk_c) check({tag, "_carryout"}, 32'(carryout), 32'(exp_c));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold_result"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int seen_done;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; control = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_flags", {29'd0, carryout, overflow, negative}, 32'd0);
        check("rst_slice", {26'd0, slice_a, slice_b, slice_cin, slice_control}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("add_ovf", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("sub_eq",  3'b011, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("xor",     3'b111, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("and",     3'b100, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("hold",    3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset partway through an add: nothing completes, outputs return to reset values.
        @(negedge clk);
        A = 8'hFF; B = 8'h01; control = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd1);
        check("mid_rst_cin", 32'(slice_cin), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'd0);

        run_op("add_wrap", 3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("b2b_sub",  3'b011, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("or",       3'b101, 8'h81, 8'h18, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
